// File: rtl/alu_pkg.sv
// Shared ALU adder constants, used when tiling lookahead group slices
// into the 16-/32-bit adders.
package alu_pkg;

    localparam int ALU_WORD = 32;
    localparam int GROUP_W  = 4;

    // Number of group slices needed to cover a word of the given width.
    function automatic int num_groups(input int word_w, input int group_w);
        return (word_w + group_w - 1) / group_w;
    endfunction

endpackage

// File: rtl/cla_bit_stage_unit_if.sv
// Operand/result bundle of one lookahead group slice; the master drives
// operands, the slave (the slice) returns registered results.
interface cla_bit_stage_unit_if #(
    parameter int WIDTH = 4
) ();

    logic             valid_in;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             g_grp;
    logic             p_grp;
    logic             c_out;
    logic             valid_out;

    modport master (
        output valid_in, x, y, c_in,
        input  sum, g_grp, p_grp, c_out, valid_out
    );

    modport slave (
        input  valid_in, x, y, c_in,
        output sum, g_grp, p_grp, c_out, valid_out
    );

endinterface

// File: rtl/bit_stage_core.sv
// One bit stage of the lookahead slice: generate, propagate and sum for a
// single bit given the carry arriving at that bit.
module bit_stage_core (
    output logic g,
    output logic p,
    output logic sum,
    input  logic x,
    input  logic y,
    input  logic c_in
);

    assign g   = x & y;
    assign p   = x ^ y;
    assign sum = p ^ c_in;

endmodule

// File: rtl/cla_bit_stage_unit.sv
// Registered carry-lookahead group slice: per-bit stage cells, a ripple carry
// into each cell, group generate/propagate and a lookahead carry-out.
module cla_bit_stage_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = GROUP_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    cla_bit_stage_unit_if.slave  bus
);

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] s_bit;
    logic [WIDTH-1:0] carry;

    logic             c_ripple;
    logic             g_acc;
    logic             p_acc;
    logic             c_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        bit_stage_core u_core (
            .g    (g_bit[i]),
            .p    (p_bit[i]),
            .sum  (s_bit[i]),
            .x    (bus.x[i]),
            .y    (bus.y[i]),
            .c_in (carry[i])
        );
    end

    // Carry into each bit plus the group terms, folded from bit 0 upward so
    // G ends as g_{W-1} | p_{W-1}(g_{W-2} | ...), independent of c_in.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path
        // leaves one unassigned and no latch is inferred; blocking '=' is
        // used here because later iterations read the updated values.
        carry    = '0;
        c_ripple = bus.c_in;
        g_acc    = 1'b0;
        p_acc    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = c_ripple;
            c_ripple = g_bit[i] | (p_bit[i] & c_ripple);
            g_acc    = g_bit[i] | (p_bit[i] & g_acc);
            p_acc    = p_acc & p_bit[i];
        end
        c_next = g_acc | (p_acc & bus.c_in);
    end

    // Results update only on valid operands; valid_out is a plain one-cycle
    // delayed copy so a consumer sees each result flagged exactly once.
    always_ff @(posedge Clk) begin
        // NOTE: registers use non-blocking '<=' so every flop samples the
        // pre-edge values regardless of statement order.
        if (Reset) begin
            bus.sum       <= '0;
            bus.g_grp     <= 1'b0;
            bus.p_grp     <= 1'b0;
            bus.c_out     <= 1'b0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                bus.sum   <= s_bit;
                bus.g_grp <= g_acc;
                bus.p_grp <= p_acc;
                bus.c_out <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_cla_bit_stage_unit.sv
// Self-checking bench for the lookahead group slice: directed cases, an
// exhaustive back-to-back sweep with a mid-stream reset, and random traffic.
module tb_cla_bit_stage_unit;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_bit_stage_unit_if #(.WIDTH(W)) bus ();

    cla_bit_stage_unit #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: what the registered outputs must hold after each edge.
    logic [W-1:0] m_sum = '0;
    logic         m_g   = 1'b0;
    logic         m_p   = 1'b0;
    logic         m_c   = 1'b0;
    logic         m_v   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic view of the slice: the sum is plain addition, G means x+y
    // overflows on its own, P means x+y sits exactly at all-ones.
    task automatic model(input bit r, input bit v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit ci);
        int unsigned total;
        int unsigned pair;
        if (r) begin
            m_sum = '0; m_g = 1'b0; m_p = 1'b0; m_c = 1'b0; m_v = 1'b0;
        end else begin
            m_v = v;
            if (v) begin
                pair  = int'(a) + int'(b);
                total = pair + int'(ci);
                m_sum = total[W-1:0];
                m_c   = (total >= (1 << W));
                m_g   = (pair >= (1 << W));
                m_p   = (pair == (1 << W) - 1);
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit ci, input string tag);
        @(negedge clk);
        rst          = r;
        bus.valid_in = v;
        bus.x        = a;
        bus.y        = b;
        bus.c_in     = ci;
        model(r, v, a, b, ci);
        @(posedge clk);
        #1;
        check({tag, ".sum"},       32'(bus.sum),       32'(m_sum));
        check({tag, ".g_grp"},     32'(bus.g_grp),     32'(m_g));
        check({tag, ".p_grp"},     32'(bus.p_grp),     32'(m_p));
        check({tag, ".c_out"},     32'(bus.c_out),     32'(m_c));
        check({tag, ".valid_out"}, 32'(bus.valid_out), 32'(m_v));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           ci;
        bit           v;
        bit           r;

        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.c_in     = 1'b0;

        // Reset beats a simultaneous valid operand pair.
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, "reset");
        check("reset.sum_const", 32'(bus.sum), 32'h0);

        step(1'b0, 1'b1, 4'b1010, 4'b0101, 1'b0, "prop_c0");
        check("prop_c0.sum_const", 32'(bus.sum), 32'hF);
        check("prop_c0.p_const",   32'(bus.p_grp), 32'h1);

        step(1'b0, 1'b1, 4'b1010, 4'b0101, 1'b1, "prop_c1");
        check("prop_c1.sum_const", 32'(bus.sum), 32'h0);
        check("prop_c1.c_const",   32'(bus.c_out), 32'h1);

        step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, "gen");
        check("gen.g_const", 32'(bus.g_grp), 32'h1);
        check("gen.p_const", 32'(bus.p_grp), 32'h0);

        step(1'b0, 1'b1, 4'h3, 4'h4, 1'b0, "hold_load");
        step(1'b0, 1'b0, 4'hF, 4'hF, 1'b0, "hold");
        check("hold.sum_const",   32'(bus.sum), 32'h7);
        check("hold.valid_const", 32'(bus.valid_out), 32'h0);

        // Every (x, y, c_in) back-to-back; one reset lands mid-stream.
        for (int i = 0; i < 512; i++) begin
            int unsigned idx;
            idx = i;
            step(i == 200, 1'b1, idx[3:0], idx[7:4], idx[8], "exh");
        end

        // Random traffic with idle gaps and occasional resets.
        for (int i = 0; i < 200; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 31) == 0);
            step(r, v, a, b, ci, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
